// File: rtl/caf_pkg.sv
// Shared constants and elaboration-time helpers for the CAF post-processing blocks.
package caf_pkg;

  localparam int TIE_FIRST = 0;
  localparam int TIE_LAST  = 1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Two squared terms of n bits each sum to at most 2^(2n-1), so 2n bits never wraps.
  function automatic int mag_bits_of(input int ib, input int qb);
    return 2 * max2(ib, qb);
  endfunction

endpackage

// File: rtl/argmax_stream_if.sv
// Sample-in / result-out handshake bundle for argmax_stream.
interface argmax_stream_if #(
  parameter int i_bits       = 12,
  parameter int q_bits       = 12,
  parameter int index_bits   = 4,
  parameter int out_max_bits = 24
);
  logic                     m_axis_tvalid;
  logic                     m_axis_tlast;
  logic signed [i_bits-1:0] xi;
  logic signed [q_bits-1:0] xq;
  logic                     s_axis_tready;
  logic                     m_axis_tready;
  logic [out_max_bits-1:0]  out_max;
  logic [index_bits-1:0]    index;
  logic                     s_axis_tvalid;

  modport master (
    output m_axis_tvalid, m_axis_tlast, xi, xq, m_axis_tready,
    input  s_axis_tready, out_max, index, s_axis_tvalid
  );

  modport slave (
    input  m_axis_tvalid, m_axis_tlast, xi, xq, m_axis_tready,
    output s_axis_tready, out_max, index, s_axis_tvalid
  );
endinterface

// File: rtl/cplx_mag_sq.sv
// Two-stage, enable-gated |x|^2 pipeline for signed I/Q samples with a valid bit
// and an opaque tag carried alongside the data.
module cplx_mag_sq
  import caf_pkg::*;
#(
  parameter int i_bits   = 12,
  parameter int q_bits   = 12,
  parameter int tag_bits = 1,
  localparam int mag_bits = mag_bits_of(i_bits, q_bits)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic [tag_bits-1:0]      in_tag,
  input  logic signed [i_bits-1:0] xi,
  input  logic signed [q_bits-1:0] xq,
  output logic                     out_valid,
  output logic [tag_bits-1:0]      out_tag,
  output logic [mag_bits-1:0]      mag
);

  logic signed [2*i_bits-1:0] xi_ext;
  logic signed [2*q_bits-1:0] xq_ext;
  logic [2*i_bits-1:0]        ii_reg;
  logic [2*q_bits-1:0]        qq_reg;
  logic                       s1_valid_reg, s2_valid_reg;
  logic [tag_bits-1:0]        s1_tag_reg, s2_tag_reg;
  logic [mag_bits-1:0]        mag_reg;

  // Sign-extend before multiplying so the square is computed at full width.
  assign xi_ext = (2*i_bits)'(xi);
  assign xq_ext = (2*q_bits)'(xq);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s1_tag_reg   <= '0;
      s2_tag_reg   <= '0;
      ii_reg       <= '0;
      qq_reg       <= '0;
      mag_reg      <= '0;
    end else if (en) begin
      s1_valid_reg <= in_valid;
      s1_tag_reg   <= in_tag;
      ii_reg       <= xi_ext * xi_ext;
      qq_reg       <= xq_ext * xq_ext;
      s2_valid_reg <= s1_valid_reg;
      s2_tag_reg   <= s1_tag_reg;
      mag_reg      <= mag_bits'(ii_reg) + mag_bits'(qq_reg);
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_tag   = s2_tag_reg;
  assign mag       = mag_reg;

endmodule

// File: rtl/argmax_stream.sv
// Streaming per-frame arg-max of |x|^2: frame counter, compare stage and a held
// result register; a pending unaccepted result stalls the entire pipeline.
module argmax_stream
  import caf_pkg::*;
#(
  parameter int buffer_length = 10,
  parameter int index_bits    = 4,
  parameter int i_bits        = 12,
  parameter int q_bits        = 12,
  parameter int out_max_bits  = 24,
  parameter int tie_last      = TIE_FIRST
) (
  input logic          clk,
  input logic          rst,
  argmax_stream_if.slave bus
);

  localparam int mag_bits = mag_bits_of(i_bits, q_bits);
  localparam int tag_bits = index_bits + 1;
  localparam logic [index_bits:0] last_cnt = (index_bits+1)'(buffer_length - 1);

  logic                    en;
  logic                    accept;
  logic                    in_last;
  logic [index_bits:0]     cnt_reg, cnt_next;
  logic                    s2_valid;
  logic [tag_bits-1:0]     s2_tag;
  logic [mag_bits-1:0]     s2_mag;
  logic                    s2_last;
  logic [index_bits-1:0]   s2_index;
  logic                    take;
  logic [mag_bits-1:0]     max_reg, max_next;
  logic [index_bits-1:0]   max_index_reg, max_index_next;
  logic [out_max_bits-1:0] out_max_reg;
  logic [index_bits-1:0]   index_reg;
  logic                    res_valid_reg;

  assign en               = ~(res_valid_reg & ~bus.m_axis_tready);
  assign accept           = bus.m_axis_tvalid & en;
  assign in_last          = (cnt_reg == last_cnt) | bus.m_axis_tlast;
  assign bus.s_axis_tready = en;

  always_comb begin
    cnt_next = cnt_reg;
    if (accept) cnt_next = in_last ? '0 : cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_reg <= '0;
    else     cnt_reg <= cnt_next;
  end

  cplx_mag_sq #(
    .i_bits  (i_bits),
    .q_bits  (q_bits),
    .tag_bits(tag_bits)
  ) u_mag (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (accept),
    .in_tag   ({in_last, cnt_reg[index_bits-1:0]}),
    .xi       (bus.xi),
    .xq       (bus.xq),
    .out_valid(s2_valid),
    .out_tag  (s2_tag),
    .mag      (s2_mag)
  );

  assign s2_last  = s2_tag[index_bits];
  assign s2_index = s2_tag[index_bits-1:0];

  // Index 0 marks the first sample of a frame, which seeds the max unconditionally.
  always_comb begin
    take = (s2_index == '0) | (s2_mag > max_reg) |
           ((tie_last == TIE_LAST) & (s2_mag == max_reg));
    max_next       = take ? s2_mag   : max_reg;
    max_index_next = take ? s2_index : max_index_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_reg       <= '0;
      max_index_reg <= '0;
      out_max_reg   <= '0;
      index_reg     <= '0;
      res_valid_reg <= 1'b0;
    end else begin
      if (en && s2_valid) begin
        if (s2_last) begin
          out_max_reg   <= max_next[mag_bits-1 -: out_max_bits];
          index_reg     <= max_index_next;
          max_reg       <= '0;
          max_index_reg <= '0;
        end else begin
          max_reg       <= max_next;
          max_index_reg <= max_index_next;
        end
      end
      if (en && s2_valid && s2_last) res_valid_reg <= 1'b1;
      else if (bus.m_axis_tready)    res_valid_reg <= 1'b0;
    end
  end

  assign bus.out_max       = out_max_reg;
  assign bus.index         = index_reg;
  assign bus.s_axis_tvalid = res_valid_reg;

endmodule
